// File: rtl/pe_dot_dsp_npack_acc.sv
// rtl/pe_dot_dsp_npack_acc.sv - sign-magnitude dot-product engine with PACK-per-DSP lanes and a saturating windowed accumulator
module pe_dot_dsp_npack_acc #(
   parameter int FEAT_W   = 8,
   parameter int FILT_W   = 8,
   parameter int LANES    = 4,
   parameter int PACK     = 2,
   parameter int MULT_LAT = 2,
   parameter int ACC_W    = 32
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      i_valid,
   input  logic                      i_first,
   input  logic                      i_last,
   input  logic [LANES*FEAT_W-1:0]   i_feature,
   input  logic [LANES*FILT_W-1:0]   i_filter,
   output logic                      o_valid,
   output logic [ACC_W-1:0]          o_result,
   output logic                      o_overflow
);

   localparam int MAG_W  = FEAT_W + FILT_W - 2;
   localparam int LVL    = $clog2(LANES);
   localparam int TREE_W = MAG_W + 1 + LVL;
   localparam int NDSP   = LANES / PACK;
   localparam int PIPE   = MULT_LAT + LVL;

   logic signed [TREE_W-1:0] w_leaf [LANES];
   logic signed [TREE_W-1:0] r_node [LANES-1];

   // Each g_dsp is one DSP slice carrying PACK lane multipliers; results do not depend on PACK.
   for (genvar d = 0; d < NDSP; d++) begin : g_dsp
      for (genvar p = 0; p < PACK; p++) begin : g_mul
         localparam int K = d * PACK + p;
         logic [FEAT_W-2:0]       w_fm;
         logic [FILT_W-2:0]       w_gm;
         logic                    w_sgn;
         logic [MAG_W-1:0]        r_mag [MULT_LAT];
         logic                    r_sgn [MULT_LAT];
         logic signed [MAG_W:0]   w_prod;

         assign w_fm  = i_feature[K*FEAT_W +: FEAT_W-1];
         assign w_gm  = i_filter[K*FILT_W +: FILT_W-1];
         assign w_sgn = i_feature[K*FEAT_W + FEAT_W-1] ^ i_filter[K*FILT_W + FILT_W-1];

         always_ff @(posedge clock) begin
            r_mag[0] <= MAG_W'(w_fm) * MAG_W'(w_gm);
            r_sgn[0] <= w_sgn;
            for (int s = 1; s < MULT_LAT; s++) begin
               r_mag[s] <= r_mag[s-1];
               r_sgn[s] <= r_sgn[s-1];
            end
         end

         // A zero magnitude negates to zero, so -0 needs no special case.
         assign w_prod = r_sgn[MULT_LAT-1] ? -$signed({1'b0, r_mag[MULT_LAT-1]})
                                           :  $signed({1'b0, r_mag[MULT_LAT-1]});
         assign w_leaf[K] = {{LVL{w_prod[MAG_W]}}, w_prod};
      end
   end

   // Tree nodes stored level by level: level l starts at index LANES - (LANES >> l).
   always_ff @(posedge clock) begin
      for (int j = 0; j < LANES/2; j++) begin
         r_node[j] <= w_leaf[2*j] + w_leaf[2*j+1];
      end
      for (int l = 1; l < LVL; l++) begin
         for (int j = 0; j < (LANES >> (l+1)); j++) begin
            r_node[LANES - (LANES >> l) + j] <=
               r_node[LANES - (LANES >> (l-1)) + 2*j] + r_node[LANES - (LANES >> (l-1)) + 2*j + 1];
         end
      end
   end

   logic [PIPE-1:0]          r_vld;
   logic [PIPE-1:0]          r_fst;
   logic [PIPE-1:0]          r_lst;
   logic [ACC_W-1:0]         r_acc;
   logic                     r_ovf;
   logic                     r_oval;
   logic [ACC_W-1:0]         r_res;
   logic                     r_oovf;

   logic                     w_av;
   logic                     w_af;
   logic                     w_al;
   logic signed [TREE_W-1:0] w_tree;
   logic [ACC_W:0]           w_base;
   logic [ACC_W:0]           w_tsx;
   logic [ACC_W:0]           w_sum;
   logic                     w_clip;
   logic [ACC_W-1:0]         w_clamp;
   logic                     w_ovf;

   assign w_av   = r_vld[PIPE-1];
   assign w_af   = r_fst[PIPE-1];
   assign w_al   = r_lst[PIPE-1];
   assign w_tree = r_node[LANES-2];

   always_comb begin
      w_base  = w_af ? '0 : {r_acc[ACC_W-1], r_acc};
      w_tsx   = {{(ACC_W+1-TREE_W){w_tree[TREE_W-1]}}, w_tree};
      w_sum   = w_base + w_tsx;
      w_clip  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
      w_clamp = w_sum[ACC_W-1:0];
      if (w_clip) begin
         w_clamp = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
      w_ovf   = (w_af ? 1'b0 : r_ovf) | w_clip;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_vld  <= '0;
         r_fst  <= '0;
         r_lst  <= '0;
         r_acc  <= '0;
         r_ovf  <= 1'b0;
         r_oval <= 1'b0;
         r_res  <= '0;
         r_oovf <= 1'b0;
      end else begin
         r_vld  <= {r_vld[PIPE-2:0], i_valid};
         r_fst  <= {r_fst[PIPE-2:0], i_first};
         r_lst  <= {r_lst[PIPE-2:0], i_last};
         r_oval <= 1'b0;
         if (w_av) begin
            r_acc <= w_clamp;
            r_ovf <= w_ovf;
            if (w_al) begin
               r_oval <= 1'b1;
               r_res  <= w_clamp;
               r_oovf <= w_ovf;
            end
         end
      end
   end

   assign o_valid    = r_oval;
   assign o_result   = r_res;
   assign o_overflow = r_oovf;

endmodule
